// File: rtl/bandai_pkg.sv
// bandai_pkg: shared register map, unlock/boot defaults and address decode helpers for the Bandai v2 mapper.
package bandai_pkg;
    localparam logic [7:0] REG_C0 = 8'hC0;
    localparam logic [7:0] REG_C1 = 8'hC1;
    localparam logic [7:0] REG_C2 = 8'hC2;
    localparam logic [7:0] REG_CE = 8'hCE;
    localparam logic [7:0] REG_CF = 8'hCF;
    localparam logic [15:0] DEF_UNLK_SEQ = {8'hA5, 8'h5A};
    localparam logic [17:0] DEF_SO_PAT = {1'b0, 16'h28A0, 1'b0};

    typedef enum logic {ST_LOCKED, ST_OPEN} unlock_state_e;

    function automatic logic [3:0] region_of(input logic [7:0] addr);
        return addr[7:4];
    endfunction
endpackage

// File: rtl/bandai_mapper_v2_if.sv
// bandai_mapper_v2_if: cartridge-bus and memory-side signals of the mapper.
interface bandai_mapper_v2_if #(parameter int RADDRW = 7);
    logic CEn, SSn, WEn, OEn;
    logic [7:0] ADDR, DQ_I, DQ_O;
    logic DQ_OE, SO, SO_OE, ROMCEn, RAMCEn, BYTEn, LOCKED;
    logic [RADDRW-1:0] RADDR;
    modport master (
        output CEn, SSn, WEn, OEn, ADDR, DQ_I,
        input  DQ_O, DQ_OE, SO, SO_OE, ROMCEn, RAMCEn, BYTEn, LOCKED, RADDR
    );
    modport slave (
        input  CEn, SSn, WEn, OEn, ADDR, DQ_I,
        output DQ_O, DQ_OE, SO, SO_OE, ROMCEn, RAMCEn, BYTEn, LOCKED, RADDR
    );
endinterface

// File: rtl/bandai_unlock_seq.sv
// bandai_unlock_seq: address-pattern unlock FSM plus the serial boot bitstream shifter.
module bandai_unlock_seq
    import bandai_pkg::*;
#(
    parameter int UNLK_LEN = 2,
    parameter logic [8*UNLK_LEN-1:0] UNLK_SEQ = DEF_UNLK_SEQ,
    parameter int SO_LEN = 18,
    parameter logic [SO_LEN-1:0] SO_PAT = DEF_SO_PAT
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [7:0] addr_i,
    input  logic       relock_i,
    output logic       open_o,
    output logic       locked_o,
    output logic       so_o,
    output logic       so_oe_o
);
    unlock_state_e state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [SO_LEN-1:0] shift_q, shift_d;
    logic so_oe_q;
    logic [7:0] exp_byte;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_LOCKED;
            step_q  <= '0;
            shift_q <= '1;
            so_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            shift_q <= shift_d;
            so_oe_q <= 1'b1;
        end
    end

    always_comb begin
        exp_byte = 8'(UNLK_SEQ >> {step_q, 3'b000});
        state_d  = state_q;
        step_d   = step_q;
        shift_d  = SO_LEN'({1'b1, shift_q} >> 1);
        if (state_q == ST_LOCKED && addr_i == exp_byte) begin
            if (step_q == 3'(UNLK_LEN - 1)) begin
                state_d = ST_OPEN;
                step_d  = '0;
                shift_d = SO_PAT;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
        // relock only commits while open, so it never races an unlock match
        if (relock_i) begin
            state_d = ST_LOCKED;
            step_d  = '0;
        end
    end

    assign open_o   = state_q == ST_OPEN;
    assign locked_o = state_q == ST_LOCKED;
    assign so_o     = shift_q[0];
    assign so_oe_o  = so_oe_q;
endmodule

// File: rtl/bandai_mapper_v2.sv
// bandai_mapper_v2: banked ROM/RAM address translation with write-edge register file and combinational reads.
module bandai_mapper_v2
    import bandai_pkg::*;
#(
    parameter int NBANKS = 2,
    parameter int RADDRW = 7,
    parameter int UNLK_LEN = 2,
    parameter logic [8*UNLK_LEN-1:0] UNLK_SEQ = DEF_UNLK_SEQ,
    parameter int SO_LEN = 18,
    parameter logic [SO_LEN-1:0] SO_PAT = DEF_SO_PAT
) (
    input logic CLK,
    input logic RSTn,
    bandai_mapper_v2_if.slave bus
);
    localparam int NREGS = NBANKS + 2;

    logic [7:0] regs_q [NREGS];
    logic byten_q, we_q;
    logic [7:0] addr_q, data_q, rd_data;
    logic open, commit, relock, rd_hit, rd_en, sel, rom_ce_n, ram_ce_n;
    logic [3:0] region;
    logic [RADDRW-1:0] raddr;

    // commit on the first high WEn sample following a low one
    assign commit = bus.WEn & we_q & open & ~(bus.SSn & bus.CEn);
    assign relock = commit && addr_q == REG_CF && data_q == 8'h00;

    bandai_unlock_seq #(
        .UNLK_LEN(UNLK_LEN), .UNLK_SEQ(UNLK_SEQ), .SO_LEN(SO_LEN), .SO_PAT(SO_PAT)
    ) u_unlock (
        .CLK(CLK), .RSTn(RSTn), .addr_i(bus.ADDR), .relock_i(relock),
        .open_o(open), .locked_o(bus.LOCKED), .so_o(bus.SO), .so_oe_o(bus.SO_OE)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '1;
            byten_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            we_q <= ~bus.WEn;
            if (!bus.WEn) begin
                addr_q <= bus.ADDR;
                data_q <= bus.DQ_I;
            end
            for (int i = 0; i < NREGS; i++)
                if (commit && addr_q == REG_C0 + 8'(i)) regs_q[i] <= data_q;
            if (commit && addr_q == REG_CE) byten_q <= ~data_q[0];
        end
    end

    always_comb begin
        rd_hit  = bus.ADDR == REG_CE;
        rd_data = {7'b0, ~byten_q};
        for (int i = 0; i < NREGS; i++) begin
            if (bus.ADDR == REG_C0 + 8'(i)) begin
                rd_hit  = 1'b1;
                rd_data = regs_q[i];
            end
        end
    end

    assign rd_en     = rd_hit & open & ~(bus.SSn & bus.CEn) & ~bus.OEn & bus.WEn;
    assign bus.DQ_OE = rd_en;
    assign bus.DQ_O  = rd_en ? rd_data : 8'h00;

    assign region   = region_of(bus.ADDR);
    assign sel      = open & bus.SSn & ~bus.CEn;
    assign ram_ce_n = byten_q ? ~(sel & region == 4'd1) : 1'b1;
    assign rom_ce_n = byten_q ? ~(sel & region >= 4'd2) : 1'b0;

    always_comb begin
        raddr = '0;
        if (region == 4'd1) raddr = RADDRW'(regs_q[1]);
        for (int i = 0; i < NBANKS; i++)
            if (region == 4'(2 + i)) raddr = RADDRW'(regs_q[2+i]);
        if (region >= 4'(2 + NBANKS)) raddr = {regs_q[0][RADDRW-5:0], region};
    end

    assign bus.RAMCEn = ram_ce_n;
    assign bus.ROMCEn = rom_ce_n;
    assign bus.BYTEn  = byten_q;
    assign bus.RADDR  = (rom_ce_n & ram_ce_n) ? '0 : raddr;
endmodule

// File: tb/tb_bandai_mapper_v2.sv
// tb_bandai_mapper_v2: directed scenarios plus randomized traffic against a behavioural mapper model.
module tb_bandai_mapper_v2;
    localparam int NBANKS = 2;
    localparam int RADDRW = 7;
    localparam int UNLK_LEN = 2;
    localparam int SO_LEN = 18;
    localparam logic [17:0] PAT = {1'b0, 16'h28A0, 1'b0};

    logic CLK = 1'b0;
    logic RSTn = 1'b1;
    int checks = 0;
    int errors = 0;

    bandai_mapper_v2_if #(.RADDRW(RADDRW)) bus ();
    bandai_mapper_v2 #(.NBANKS(NBANKS), .RADDRW(RADDRW)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

    always #5 CLK = ~CLK;

    bit [7:0] seq_bytes [UNLK_LEN] = '{8'h5A, 8'hA5};
    bit       m_open, m_byten, m_prev_low, m_sooe;
    int       m_step;
    bit       m_soq [$];
    bit [7:0] m_reg [int];
    bit [7:0] m_cap_a, m_cap_d;

    task automatic model_reset();
        m_open = 0; m_step = 0; m_byten = 1; m_prev_low = 0; m_sooe = 0;
        m_soq.delete();
        m_reg.delete();
        for (int a = 'hC0; a <= 'hC1 + NBANKS; a++) m_reg[a] = 8'hFF;
    endtask

    task automatic model_edge();
        bit commit;
        commit = bus.WEn && m_prev_low && m_open && !(bus.SSn && bus.CEn);
        if (commit && m_reg.exists(int'(m_cap_a))) m_reg[m_cap_a] = m_cap_d;
        if (commit && m_cap_a == 8'hCE) m_byten = !m_cap_d[0];
        if (m_soq.size() > 0) void'(m_soq.pop_front());
        if (!m_open && bus.ADDR == seq_bytes[m_step]) begin
            if (m_step == UNLK_LEN - 1) begin
                m_open = 1; m_step = 0;
                m_soq.delete();
                for (int j = 0; j < SO_LEN; j++) m_soq.push_back(PAT[j]);
            end else m_step++;
        end
        if (commit && m_cap_a == 8'hCF && m_cap_d == 8'h00) begin m_open = 0; m_step = 0; end
        m_prev_low = !bus.WEn;
        if (!bus.WEn) begin m_cap_a = bus.ADDR; m_cap_d = bus.DQ_I; end
        m_sooe = 1;
    endtask

    function automatic bit e_sel(); return m_open && bus.SSn && !bus.CEn; endfunction
    function automatic bit e_rom(); return !m_byten ? 1'b0 : !(e_sel() && bus.ADDR[7:4] >= 2); endfunction
    function automatic bit e_ram(); return !m_byten ? 1'b1 : !(e_sel() && bus.ADDR[7:4] == 1); endfunction
    function automatic bit e_dqoe();
        return m_open && !(bus.SSn && bus.CEn) && !bus.OEn && bus.WEn &&
               (m_reg.exists(int'(bus.ADDR)) || bus.ADDR == 8'hCE);
    endfunction
    function automatic bit [7:0] e_dqo();
        if (!e_dqoe()) return 8'h00;
        return bus.ADDR == 8'hCE ? {7'b0, !m_byten} : m_reg[bus.ADDR];
    endfunction
    function automatic bit [RADDRW-1:0] e_raddr();
        int r, v;
        r = int'(bus.ADDR[7:4]);
        if (e_rom() && e_ram()) v = 0;
        else if (r == 1) v = m_reg['hC1];
        else if (r >= 2 && r < 2 + NBANKS) v = m_reg['hC0 + r];
        else if (r >= 2 + NBANKS) v = m_reg['hC0] * 16 + r;
        else v = 0;
        return RADDRW'(v % (1 << RADDRW));
    endfunction

    task automatic cyc();
        if (!RSTn) model_reset(); else model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.CEn = 1; bus.SSn = 1; bus.WEn = 1; bus.OEn = 1; bus.ADDR = 8'h00; bus.DQ_I = 8'h00;
    endtask

    task automatic do_reset();
        idle();
        RSTn = 0;
        model_reset();
        @(posedge CLK);
        #1;
        RSTn = 1;
    endtask

    task automatic bus_write(input bit [7:0] a, input bit [7:0] d);
        bus.ADDR = a; bus.DQ_I = d; bus.SSn = 0; bus.CEn = 0; bus.WEn = 0;
        cyc();
        bus.WEn = 1;
        cyc();
        idle();
    endtask

    task automatic unlock();
        bus.ADDR = 8'h5A; cyc();
        bus.ADDR = 8'hA5; cyc();
        bus.ADDR = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        RSTn = 0;
        #1;
        checks++; if (bus.LOCKED !== 1'b1) begin errors++; $display("FAIL rst_locked: got %b want 1", bus.LOCKED); end
        checks++; if (bus.SO !== 1'b1) begin errors++; $display("FAIL rst_so: got %b want 1", bus.SO); end
        checks++; if (bus.SO_OE !== 1'b0) begin errors++; $display("FAIL rst_so_oe: got %b want 0", bus.SO_OE); end
        checks++; if (bus.DQ_OE !== 1'b0) begin errors++; $display("FAIL rst_dq_oe: got %b want 0", bus.DQ_OE); end
        checks++; if ({bus.ROMCEn, bus.RAMCEn, bus.BYTEn} !== 3'b111) begin errors++; $display("FAIL rst_enables: got %b want 111", {bus.ROMCEn, bus.RAMCEn, bus.BYTEn}); end
        checks++; if (bus.RADDR !== 7'h00) begin errors++; $display("FAIL rst_raddr: got %h want 00", bus.RADDR); end
        model_reset();
        @(posedge CLK);
        #1;
        RSTn = 1;
        cyc();
        checks++; if (bus.SO_OE !== 1'b1) begin errors++; $display("FAIL rst_so_oe_rise: got %b want 1", bus.SO_OE); end
        checks++; if (bus.LOCKED !== 1'b1) begin errors++; $display("FAIL rst_still_locked: got %b want 1", bus.LOCKED); end
    endtask

    task automatic test_unlock();
        do_reset();
        bus.ADDR = 8'h5A; cyc();
        checks++; if (bus.LOCKED !== 1'b1) begin errors++; $display("FAIL unlock_step1: got %b want 1", bus.LOCKED); end
        bus.ADDR = 8'hA5; cyc();
        bus.ADDR = 8'h00;
        checks++; if (bus.LOCKED !== 1'b0) begin errors++; $display("FAIL unlock_open: got %b want 0", bus.LOCKED); end
        checks++; if (bus.SO !== PAT[0]) begin errors++; $display("FAIL unlock_so0: got %b want %b", bus.SO, PAT[0]); end
        for (int j = 1; j < SO_LEN; j++) begin
            cyc();
            checks++; if (bus.SO !== PAT[j]) begin errors++; $display("FAIL unlock_so%0d: got %b want %b", j, bus.SO, PAT[j]); end
        end
        cyc();
        checks++; if (bus.SO !== 1'b1) begin errors++; $display("FAIL unlock_so_done: got %b want 1", bus.SO); end
    endtask

    task automatic test_mismatch_hold();
        do_reset();
        bus_write(8'hC2, 8'h05);
        bus.ADDR = 8'h5A; cyc();
        bus.ADDR = 8'h33; cyc();
        checks++; if (bus.LOCKED !== 1'b1) begin errors++; $display("FAIL hold_locked: got %b want 1", bus.LOCKED); end
        bus.ADDR = 8'hA5; cyc();
        checks++; if (bus.LOCKED !== 1'b0) begin errors++; $display("FAIL hold_open: got %b want 0", bus.LOCKED); end
        bus.CEn = 0; bus.SSn = 1; bus.ADDR = 8'h20;
        #1;
        checks++; if (bus.ROMCEn !== 1'b0) begin errors++; $display("FAIL locked_wr_romce: got %b want 0", bus.ROMCEn); end
        checks++; if (bus.RADDR !== 7'h7F) begin errors++; $display("FAIL locked_wr_dropped: got %h want 7f", bus.RADDR); end
        cyc();
        idle();
    endtask

    task automatic test_banks();
        bus_write(8'hC2, 8'h05);
        bus.CEn = 0; bus.SSn = 1; bus.ADDR = 8'h20;
        #1;
        checks++; if ({bus.ROMCEn, bus.RAMCEn} !== 2'b01) begin errors++; $display("FAIL rom0_ce: got %b want 01", {bus.ROMCEn, bus.RAMCEn}); end
        checks++; if (bus.RADDR !== 7'h05) begin errors++; $display("FAIL rom0_raddr: got %h want 05", bus.RADDR); end
        cyc();
        bus.ADDR = 8'h10;
        #1;
        checks++; if ({bus.ROMCEn, bus.RAMCEn} !== 2'b10) begin errors++; $display("FAIL ram_ce: got %b want 10", {bus.ROMCEn, bus.RAMCEn}); end
        checks++; if (bus.RADDR !== 7'h7F) begin errors++; $display("FAIL ram_raddr: got %h want 7f", bus.RADDR); end
        cyc();
        bus.ADDR = 8'h30;
        #1;
        checks++; if (bus.RADDR !== 7'h7F) begin errors++; $display("FAIL rom1_raddr: got %h want 7f", bus.RADDR); end
        cyc();
        bus.ADDR = 8'h00;
        #1;
        checks++; if ({bus.ROMCEn, bus.RAMCEn, bus.RADDR} !== {2'b11, 7'h00}) begin errors++; $display("FAIL region0: got %b/%h want 11/00", {bus.ROMCEn, bus.RAMCEn}, bus.RADDR); end
        cyc();
        idle();
        bus_write(8'hC0, 8'h03);
        bus.CEn = 0; bus.SSn = 1; bus.ADDR = 8'h70;
        #1;
        checks++; if (bus.RADDR !== 7'h37) begin errors++; $display("FAIL lao_r7: got %h want 37", bus.RADDR); end
        cyc();
        bus.ADDR = 8'h40;
        #1;
        checks++; if (bus.RADDR !== 7'h34) begin errors++; $display("FAIL lao_r4: got %h want 34", bus.RADDR); end
        cyc();
        idle();
        bus.SSn = 0; bus.OEn = 0; bus.ADDR = 8'hC0;
        #1;
        checks++; if ({bus.DQ_OE, bus.DQ_O} !== {1'b1, 8'h03}) begin errors++; $display("FAIL read_c0: got %b/%h want 1/03", bus.DQ_OE, bus.DQ_O); end
        cyc();
        bus.ADDR = 8'hC3;
        #1;
        checks++; if ({bus.DQ_OE, bus.DQ_O} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL read_c3: got %b/%h want 1/ff", bus.DQ_OE, bus.DQ_O); end
        cyc();
        bus.ADDR = 8'hC4;
        #1;
        checks++; if ({bus.DQ_OE, bus.DQ_O} !== {1'b0, 8'h00}) begin errors++; $display("FAIL read_c4: got %b/%h want 0/00", bus.DQ_OE, bus.DQ_O); end
        cyc();
        idle();
    endtask

    task automatic test_byte_relock();
        bus_write(8'hCE, 8'h01);
        checks++; if (bus.BYTEn !== 1'b0) begin errors++; $display("FAIL byten_set: got %b want 0", bus.BYTEn); end
        checks++; if ({bus.ROMCEn, bus.RAMCEn} !== 2'b01) begin errors++; $display("FAIL byten_force: got %b want 01", {bus.ROMCEn, bus.RAMCEn}); end
        bus.SSn = 0; bus.OEn = 0; bus.ADDR = 8'hCE;
        #1;
        checks++; if ({bus.DQ_OE, bus.DQ_O} !== {1'b1, 8'h01}) begin errors++; $display("FAIL read_ce: got %b/%h want 1/01", bus.DQ_OE, bus.DQ_O); end
        cyc();
        idle();
        bus_write(8'hCF, 8'h01);
        checks++; if (bus.LOCKED !== 1'b0) begin errors++; $display("FAIL relock_ignored: got %b want 0", bus.LOCKED); end
        bus_write(8'hCF, 8'h00);
        checks++; if (bus.LOCKED !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", bus.LOCKED); end
        bus.SSn = 0; bus.OEn = 0; bus.ADDR = 8'hC0;
        #1;
        checks++; if (bus.DQ_OE !== 1'b0) begin errors++; $display("FAIL relock_read: got %b want 0", bus.DQ_OE); end
        cyc();
        idle();
        unlock();
        bus.SSn = 0; bus.OEn = 0; bus.ADDR = 8'hC2;
        #1;
        checks++; if ({bus.DQ_OE, bus.DQ_O} !== {1'b1, 8'h05}) begin errors++; $display("FAIL retained_c2: got %b/%h want 1/05", bus.DQ_OE, bus.DQ_O); end
        checks++; if (bus.BYTEn !== 1'b0) begin errors++; $display("FAIL retained_byten: got %b want 0", bus.BYTEn); end
        cyc();
        idle();
        bus_write(8'hCE, 8'h00);
        checks++; if (bus.BYTEn !== 1'b1) begin errors++; $display("FAIL byten_clear: got %b want 1", bus.BYTEn); end
    endtask

    task automatic test_async_reset();
        bus_write(8'hCE, 8'h01);
        bus_write(8'hCF, 8'h00);
        unlock();
        repeat (5) cyc();
        checks++; if (bus.SO !== PAT[5]) begin errors++; $display("FAIL mid_shift_so: got %b want %b", bus.SO, PAT[5]); end
        RSTn = 0;
        #1;
        checks++; if ({bus.SO, bus.SO_OE, bus.LOCKED} !== 3'b101) begin errors++; $display("FAIL arst_so_lock: got %b want 101", {bus.SO, bus.SO_OE, bus.LOCKED}); end
        checks++; if ({bus.ROMCEn, bus.RAMCEn, bus.BYTEn, bus.RADDR} !== {3'b111, 7'h00}) begin errors++; $display("FAIL arst_mem: got %b/%h want 111/00", {bus.ROMCEn, bus.RAMCEn, bus.BYTEn}, bus.RADDR); end
        cyc();
        RSTn = 1;
        unlock();
        bus.CEn = 0; bus.SSn = 1; bus.ADDR = 8'h20;
        #1;
        checks++; if (bus.RADDR !== 7'h7F) begin errors++; $display("FAIL arst_bank: got %h want 7f", bus.RADDR); end
        cyc();
        idle();
    endtask

    task automatic test_random();
        bit [7:0] pool [11] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hCE, 8'hCF, 8'h10, 8'h20, 8'h30, 8'h70};
        logic [21:0] got, want;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (!m_open && $urandom_range(0, 1) == 0) bus.ADDR = seq_bytes[m_step];
            else if ($urandom_range(0, 11) == 11) bus.ADDR = 8'($urandom);
            else bus.ADDR = pool[$urandom_range(0, 10)];
            bus.DQ_I = 8'($urandom);
            if (bus.ADDR == 8'hCF && $urandom_range(0, 3) == 0) bus.DQ_I = 8'h00;
            bus.WEn = $urandom_range(0, 2) != 0;
            bus.CEn = 1'($urandom_range(0, 1));
            bus.SSn = 1'($urandom_range(0, 1));
            bus.OEn = 1'($urandom_range(0, 1));
            #1;
            got  = {bus.LOCKED, bus.SO, bus.SO_OE, bus.DQ_OE, bus.DQ_O, bus.ROMCEn, bus.RAMCEn, bus.BYTEn, bus.RADDR};
            want = {!m_open, (m_soq.size() > 0) ? m_soq[0] : 1'b1, m_sooe, e_dqoe(), e_dqo(), e_rom(), e_ram(), m_byten, e_raddr()};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rnd_outputs cyc %0d addr %h: got %h want %h", n, bus.ADDR, got, want);
            end
            cyc();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_mismatch_hold();
        test_banks();
        test_byte_relock();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
